v810_mem_resp: RTL

//  V810 bus responder for the RAM (and optionally ROM) chip-select decoded by fx_ga.

---
 rtl/v810_mem_resp_pkg.sv | 45 ++++
 rtl/v810_mem_resp_if.sv | 33 +++
 rtl/v810_mem_resp.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/v810_mem_resp_pkg.sv
// Shared types for the V810 memory responder: FSM states, half selectors and
// the per-beat backend request bundle.
package v810_mem_resp_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LO   = 3'd1,
        HI   = 3'd2,
        WAIT = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

    localparam int WAIT_W = 4;

    // half is the low bit of the backend word address; the upper bits come
    // straight from the latched CPU address.
    typedef struct packed {
        logic        half;
        logic        we;
        logic [1:0]  be;
        logic [15:0] d;
    } beat_t;

    localparam beat_t BEAT_NONE = '0;

    function automatic logic half_used(input logic [1:0] ben_half);
        return ben_half != 2'b11;
    endfunction

    function automatic beat_t make_beat(input logic        half,
                                        input logic        we,
                                        input logic [1:0]  ben_half,
                                        input logic [15:0] d);
        beat_t b;
        b.half = half;
        b.we   = we;
        b.be   = ~ben_half;
        b.d    = d;
        return b;
    endfunction

endpackage

// File: rtl/v810_mem_resp_if.sv
// CPU-side V810 bus and 16-bit backend REQ/ACK port of the memory responder.
interface v810_mem_resp_if #(
    parameter int ADDR_W = 21
);
    logic              CE;
    logic              BCYSTn;
    logic              CEn;
    logic [ADDR_W-1:0] A;
    logic              RW;
    logic [3:0]        BEn;
    logic [31:0]       DI;
    logic [31:0]       DO;
    logic              READYn;

    logic              MEM_REQ;
    logic              MEM_ACK;
    logic [ADDR_W-2:0] MEM_A;
    logic              MEM_WE;
    logic [1:0]        MEM_BE;
    logic [15:0]       MEM_D;
    logic [15:0]       MEM_Q;

    modport slave (
        input  CE, BCYSTn, CEn, A, RW, BEn, DI, MEM_ACK, MEM_Q,
        output DO, READYn, MEM_REQ, MEM_A, MEM_WE, MEM_BE, MEM_D
    );

    modport master (
        output CE, BCYSTn, CEn, A, RW, BEn, DI, MEM_ACK, MEM_Q,
        input  DO, READYn, MEM_REQ, MEM_A, MEM_WE, MEM_BE, MEM_D
    );

endinterface

// File: rtl/v810_mem_resp.sv
// V810 bus responder: splits each 32-bit CPU cycle into 0-2 backend beats of
// 16 bits and returns read data with exactly one CE-sampled READYn.
//
//   state | meaning
//   IDLE  | waiting for CE & ~BCYSTn & ~CEn
//   LO    | backend beat for D[15:0], REQ held until ACK
//   HI    | backend beat for D[31:16], REQ held until ACK
//   WAIT  | beats finished, running out the minimum access time
//   DONE  | READYn low until the CPU samples it on CE
module v810_mem_resp
    import v810_mem_resp_pkg::*;
#(
    parameter int ADDR_W   = 21,
    parameter int MIN_WAIT = 0
) (
    input logic            CLK,
    input logic            RES,
    v810_mem_resp_if.slave bus
);

    localparam logic [WAIT_W-1:0] MIN_WAIT_C = WAIT_W'(MIN_WAIT);

    state_t             state;
    state_t             state_nx;
    logic [ADDR_W-3:0]  word_base;
    logic               rw_q;
    logic [3:0]         ben_q;
    logic [31:0]        di_q;
    logic               need_hi_q;
    logic               abort_q;
    logic [WAIT_W-1:0]  wait_rem;
    logic [31:0]        do_q;

    logic               start;
    logic               ce_drop;
    logic               abort_any;
    logic               beat_act;
    beat_t              beat;

    assign start     = bus.CE & ~bus.BCYSTn & ~bus.CEn;
    assign ce_drop   = bus.CE & bus.CEn;
    assign abort_any = abort_q | ce_drop;
    assign beat_act  = (state == LO) || (state == HI);

    always_ff @(posedge CLK) begin
        if (RES) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (half_used(bus.BEn[1:0])) begin
                        state_nx = LO;
                    end else if (half_used(bus.BEn[3:2])) begin
                        state_nx = HI;
                    end else begin
                        state_nx = WAIT;
                    end
                end
            end
            LO: begin
                if (bus.MEM_ACK) begin
                    if (abort_any) begin
                        state_nx = IDLE;
                    end else if (need_hi_q) begin
                        state_nx = HI;
                    end else begin
                        state_nx = WAIT;
                    end
                end
            end
            HI: begin
                if (bus.MEM_ACK) begin
                    state_nx = abort_any ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (ce_drop) begin
                    state_nx = IDLE;
                end else if (wait_rem == '0) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (bus.CE) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Cycle context is latched at start and frozen, so MEM_* cannot move while REQ waits for ACK.
    always_ff @(posedge CLK) begin
        if (RES) begin
            word_base <= '0;
            rw_q      <= 1'b1;
            ben_q     <= 4'hF;
            di_q      <= '0;
            need_hi_q <= 1'b0;
            abort_q   <= 1'b0;
            wait_rem  <= '0;
            do_q      <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                word_base <= bus.A[ADDR_W-1:2];
                rw_q      <= bus.RW;
                ben_q     <= bus.BEn;
                di_q      <= bus.DI;
                need_hi_q <= half_used(bus.BEn[3:2]);
                abort_q   <= 1'b0;
                wait_rem  <= MIN_WAIT_C;
                do_q      <= '0;
            end
        end else begin
            if (bus.CE && (wait_rem != '0)) begin
                wait_rem <= wait_rem - 1'b1;
            end
            if (beat_act && ce_drop) begin
                abort_q <= 1'b1;
            end
            if (beat_act && bus.MEM_ACK && rw_q) begin
                if (state == HI) begin
                    do_q[31:16] <= bus.MEM_Q;
                end else begin
                    do_q[15:0] <= bus.MEM_Q;
                end
            end
        end
    end

    always_comb begin
        beat = BEAT_NONE;
        case (state)
            LO:      beat = make_beat(HALF_LO, ~rw_q, ben_q[1:0], di_q[15:0]);
            HI:      beat = make_beat(HALF_HI, ~rw_q, ben_q[3:2], di_q[31:16]);
            default: beat = BEAT_NONE;
        endcase
    end

    assign bus.MEM_REQ = beat_act;
    assign bus.MEM_A   = beat_act ? {word_base, beat.half} : '0;
    assign bus.MEM_WE  = beat.we;
    assign bus.MEM_BE  = beat.be;
    assign bus.MEM_D   = beat.d;
    assign bus.DO      = do_q;
    assign bus.READYn  = (state != DONE);

endmodule
